uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 167 ++++++++++++++++
 tb/tb_uart_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter clocked at 16x baud: start bit, 5..9 data bits (LSB first),
// optional even/odd parity, and one or two stop bits, with a ready/valid handshake.
module uart_tx (
  input  logic       clk_16bd,
  input  logic       rst_n,
  input  logic [8:0] data,
  input  logic       data_valid,
  output logic       ready,
  input  logic       parity,
  input  logic       parity_type,
  input  logic       stop_bits,
  input  logic [3:0] frame_length,
  output logic       Tx,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     r_state;
  logic [3:0] r_sampleCnt;
  logic [3:0] r_dataCnt;
  logic [8:0] r_data;
  logic       r_parityEn;
  logic       r_parityType;
  logic       r_stopBits;
  logic [3:0] r_len;
  logic       r_tx;
  logic       r_txDone;

  state_t     w_stateNext;
  logic [3:0] w_sampleCntNext;
  logic [3:0] w_dataCntNext;
  logic       w_txNext;
  logic       w_txDoneNext;
  logic       w_accept;
  logic [3:0] w_len;
  logic [8:0] w_mask;
  logic       w_parityBit;
  logic       w_bitEnd;

  assign ready       = (r_state == IDLE);
  assign w_accept    = ready && data_valid;
  assign w_bitEnd    = (r_sampleCnt == 4'd15);
  // Bits above L are zeroed at capture, so parity can cover the whole register.
  assign w_parityBit = (^r_data) ^ r_parityType;
  assign Tx          = r_tx;
  assign tx_done     = r_txDone;

  always_comb begin
    w_len = frame_length;
    if (frame_length < 4'd5) begin
      w_len = 4'd5;
    end else if (frame_length > 4'd9) begin
      w_len = 4'd9;
    end
    w_mask = '0;
    for (int i = 0; i < 9; i++) begin
      w_mask[i] = (4'(i) < w_len);
    end
  end

  // Tx is computed for the state being entered so the registered line changes
  // on the same edge as the state.
  always_comb begin
    w_stateNext     = r_state;
    w_sampleCntNext = r_sampleCnt + 4'd1;
    w_dataCntNext   = r_dataCnt;
    w_txNext        = 1'b1;
    w_txDoneNext    = 1'b0;
    case (r_state)
      IDLE: begin
        w_sampleCntNext = 4'd0;
        w_dataCntNext   = 4'd0;
        if (data_valid) begin
          w_stateNext = START;
          w_txNext    = 1'b0;
        end
      end
      START: begin
        w_txNext = 1'b0;
        if (w_bitEnd) begin
          w_stateNext   = DATA;
          w_dataCntNext = 4'd0;
          w_txNext      = r_data[0];
        end
      end
      DATA: begin
        w_txNext = r_data[r_dataCnt];
        if (w_bitEnd) begin
          if (r_dataCnt == r_len - 4'd1) begin
            w_dataCntNext = 4'd0;
            if (r_parityEn) begin
              w_stateNext = PARITY;
              w_txNext    = w_parityBit;
            end else begin
              w_stateNext = STOP;
              w_txNext    = 1'b1;
            end
          end else begin
            w_dataCntNext = r_dataCnt + 4'd1;
            w_txNext      = r_data[r_dataCnt + 4'd1];
          end
        end
      end
      PARITY: begin
        w_txNext = w_parityBit;
        if (w_bitEnd) begin
          w_stateNext   = STOP;
          w_dataCntNext = 4'd0;
          w_txNext      = 1'b1;
        end
      end
      STOP: begin
        if (w_bitEnd) begin
          if (r_stopBits && (r_dataCnt == 4'd0)) begin
            w_dataCntNext = 4'd1;
          end else begin
            w_stateNext   = IDLE;
            w_dataCntNext = 4'd0;
            w_txDoneNext  = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext     = IDLE;
        w_sampleCntNext = 4'd0;
        w_dataCntNext   = 4'd0;
        w_txNext        = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_16bd or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sampleCnt  <= 4'd0;
      r_dataCnt    <= 4'd0;
      r_data       <= 9'd0;
      r_parityEn   <= 1'b0;
      r_parityType <= 1'b0;
      r_stopBits   <= 1'b0;
      r_len        <= 4'd0;
      r_tx         <= 1'b1;
      r_txDone     <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_sampleCnt <= w_sampleCntNext;
      r_dataCnt   <= w_dataCntNext;
      r_tx        <= w_txNext;
      r_txDone    <= w_txDoneNext;
      if (w_accept) begin
        r_data       <= data & w_mask;
        r_parityEn   <= parity;
        r_parityType <= parity_type;
        r_stopBits   <= stop_bits;
        r_len        <= w_len;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: each scenario checks {Tx, ready, tx_done} on every
// falling edge against hand-written bit sequences.
module tb_uart_tx;

  logic       clk_16bd = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] data = 9'd0;
  logic       data_valid = 1'b0;
  logic       ready;
  logic       parity = 1'b0;
  logic       parity_type = 1'b0;
  logic       stop_bits = 1'b0;
  logic [3:0] frame_length = 4'd8;
  logic       Tx;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  uart_tx dut (
    .clk_16bd     (clk_16bd),
    .rst_n        (rst_n),
    .data         (data),
    .data_valid   (data_valid),
    .ready        (ready),
    .parity       (parity),
    .parity_type  (parity_type),
    .stop_bits    (stop_bits),
    .frame_length (frame_length),
    .Tx           (Tx),
    .tx_done      (tx_done)
  );

  always #5 clk_16bd = ~clk_16bd;

  // Presents a frame request before a rising edge; returns 1 time unit after it.
  task applyStimulus(input logic [8:0] d, input logic [3:0] fl, input logic p,
                     input logic pt, input logic sb, input logic hold);
    @(negedge clk_16bd);
    data         = d;
    frame_length = fl;
    parity       = p;
    parity_type  = pt;
    stop_bits    = sb;
    data_valid   = 1'b1;
    @(posedge clk_16bd);
    #1;
    if (!hold) data_valid = 1'b0;
  endtask

  task test_reset;
    logic [2:0] exp;
    logic seq[12];
    seq = '{0,1,0,1,0,0,1,0,1,1,1,1};
    rst_n = 1'b0;
    data = 9'h0A5; frame_length = 4'd8; parity = 1'b0; stop_bits = 1'b0;
    data_valid = 1'b1;
    repeat (3) @(posedge clk_16bd);
    #2;
    checks++;
    if ({Tx, ready, tx_done} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL reset_hold got %b expected %b", {Tx, ready, tx_done}, 3'b110);
    end
    @(negedge clk_16bd);
    rst_n = 1'b1;
    @(posedge clk_16bd);
    #1 data_valid = 1'b0;
    for (int k = 0; k <= 160; k++) begin
      @(negedge clk_16bd);
      exp = (k == 160) ? 3'b111 : {seq[k/16], 2'b00};
      checks++;
      if ({Tx, ready, tx_done} !== exp) begin
        errors++;
        $display("[TB] FAIL first_accept k=%0d got %b expected %b", k, {Tx, ready, tx_done}, exp);
      end
    end
  endtask

  task test_8n1;
    logic [2:0] exp;
    logic seq[12];
    seq = '{0,1,0,1,0,0,1,0,1,1,1,1};
    applyStimulus(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 160; k++) begin
      @(negedge clk_16bd);
      exp = (k == 160) ? 3'b111 : {seq[k/16], 2'b00};
      checks++;
      if ({Tx, ready, tx_done} !== exp) begin
        errors++;
        $display("[TB] FAIL 8n1 k=%0d got %b expected %b", k, {Tx, ready, tx_done}, exp);
      end
    end
  endtask

  task test_8e2;
    logic [2:0] exp;
    logic seq[12];
    seq = '{0,1,1,1,0,0,0,0,0,1,1,1};
    applyStimulus(9'h007, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k <= 192; k++) begin
      @(negedge clk_16bd);
      exp = (k == 192) ? 3'b111 : {seq[k/16], 2'b00};
      checks++;
      if ({Tx, ready, tx_done} !== exp) begin
        errors++;
        $display("[TB] FAIL 8e2 k=%0d got %b expected %b", k, {Tx, ready, tx_done}, exp);
      end
    end
  endtask

  task test_5o1_clamp;
    logic [2:0] exp;
    logic seq[12];
    seq = '{0,0,0,0,0,1,0,1,1,1,1,1};
    applyStimulus(9'h1F0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 128; k++) begin
      @(negedge clk_16bd);
      exp = (k == 128) ? 3'b111 : {seq[k/16], 2'b00};
      checks++;
      if ({Tx, ready, tx_done} !== exp) begin
        errors++;
        $display("[TB] FAIL 5o1_clamp k=%0d got %b expected %b", k, {Tx, ready, tx_done}, exp);
      end
    end
  endtask

  task test_9bit_changes;
    logic [2:0] exp;
    logic seq[12];
    seq = '{0,0,0,0,0,0,0,0,0,1,1,1};
    applyStimulus(9'h100, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 176; k++) begin
      @(negedge clk_16bd);
      exp = (k == 176) ? 3'b111 : {seq[k/16], 2'b00};
      checks++;
      if ({Tx, ready, tx_done} !== exp) begin
        errors++;
        $display("[TB] FAIL 9bit_changes k=%0d got %b expected %b", k, {Tx, ready, tx_done}, exp);
      end
      if (k == 40) begin
        data = 9'h0FF; frame_length = 4'd5; parity = 1'b1;
        parity_type = 1'b1; stop_bits = 1'b1; data_valid = 1'b1;
      end
      if (k == 41) data_valid = 1'b0;
    end
  endtask

  task test_back_to_back;
    logic [2:0] exp;
    logic seqA[12];
    logic seqB[12];
    seqA = '{0,0,0,1,1,1,1,0,0,1,1,1};
    seqB = '{0,1,1,0,0,0,0,1,1,1,1,1};
    applyStimulus(9'h03C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= 322; k++) begin
      @(negedge clk_16bd);
      if (k < 160)       exp = {seqA[k/16], 2'b00};
      else if (k == 160) exp = 3'b111;
      else if (k < 321)  exp = {seqB[(k-161)/16], 2'b00};
      else if (k == 321) exp = 3'b111;
      else               exp = 3'b110;
      checks++;
      if ({Tx, ready, tx_done} !== exp) begin
        errors++;
        $display("[TB] FAIL back_to_back k=%0d got %b expected %b", k, {Tx, ready, tx_done}, exp);
      end
      if (k == 5) data = 9'h0C3;
      if (k == 161) data_valid = 1'b0;
    end
  endtask

  task test_reset_midframe;
    logic [2:0] exp;
    logic seqA[12];
    logic seqB[12];
    seqA = '{0,1,0,1,0,0,1,0,1,1,1,1};
    seqB = '{0,0,1,0,1,1,0,1,0,1,1,1};
    applyStimulus(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 70; k++) begin
      @(negedge clk_16bd);
      exp = {seqA[k/16], 2'b00};
      checks++;
      if ({Tx, ready, tx_done} !== exp) begin
        errors++;
        $display("[TB] FAIL pre_reset k=%0d got %b expected %b", k, {Tx, ready, tx_done}, exp);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({Tx, ready, tx_done} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL reset_async got %b expected %b", {Tx, ready, tx_done}, 3'b110);
    end
    repeat (3) @(posedge clk_16bd);
    @(negedge clk_16bd);
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_16bd);
      checks++;
      if ({Tx, ready, tx_done} !== 3'b110) begin
        errors++;
        $display("[TB] FAIL post_reset_idle k=%0d got %b expected %b", k, {Tx, ready, tx_done}, 3'b110);
      end
    end
    applyStimulus(9'h15A, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 160; k++) begin
      @(negedge clk_16bd);
      exp = (k == 160) ? 3'b111 : {seqB[k/16], 2'b00};
      checks++;
      if ({Tx, ready, tx_done} !== exp) begin
        errors++;
        $display("[TB] FAIL fresh_frame k=%0d got %b expected %b", k, {Tx, ready, tx_done}, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_8e2;
    test_5o1_clamp;
    test_9bit_changes;
    test_back_to_back;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
